// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse width meter.
package pulse_meter_pkg;

    localparam int PM_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        M_WAIT,
        M_CNT
    } meas_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_OFFER,
        O_RELEASE
    } out_state_t;

    // Saturating increment; callers size-cast the result back to the counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max_val);
        return (count >= max_val) ? max_val : count + 32'd1;
    endfunction

endpackage

// File: rtl/pulse_meter_if.sv
// Result handshake between the pulse meter and its consumer.
// The ovf flag is present only when PULSE_METER_OVF_EN is defined.
interface pulse_meter_if
    import pulse_meter_pkg::*;
#(
    parameter int W = PM_W_DEFAULT
);

    logic         rfd;
    logic         dav_;
    logic [W-1:0] z;
    logic         lost;
`ifdef PULSE_METER_OVF_EN
    logic         ovf;

    modport master (input rfd, output dav_, output z, output lost, output ovf);
    modport slave  (output rfd, input dav_, input z, input lost, input ovf);
`else
    modport master (input rfd, output dav_, output z, output lost);
    modport slave  (output rfd, input dav_, input z, input lost);
`endif

endinterface

// File: rtl/pulse_meter_tx.sv
// Pending-result register plus the dav_/rfd output handshake FSM.
//
//   state      | meaning
//   O_IDLE     | nothing offered; loads z from pend when pend_v is set
//   O_OFFER    | dav_=0, holding z until the consumer drops rfd
//   O_RELEASE  | dav_=1, waiting for rfd to return high
module pulse_meter_tx
    import pulse_meter_pkg::*;
#(
    parameter int DW = PM_W_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] data,
    input  logic          rfd,
    output logic          dav_,
    output logic [DW-1:0] z,
    output logic          lost
);

    out_state_t    state, state_nxt;
    logic [DW-1:0] pend, pend_nxt;
    logic          pend_v, pend_v_nxt;
    logic [DW-1:0] z_nxt;
    logic          dav_nxt;
    logic          lost_nxt;
    logic          consume;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= O_IDLE;
            pend   <= '0;
            pend_v <= 1'b0;
            z      <= '0;
            dav_   <= 1'b1;
            lost   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            pend_v <= pend_v_nxt;
            z      <= z_nxt;
            dav_   <= dav_nxt;
            lost   <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        z_nxt      = z;
        dav_nxt    = dav_;
        lost_nxt   = lost;
        consume    = 1'b0;

        case (state)
            O_IDLE: begin
                if (pend_v) begin
                    z_nxt     = pend;
                    dav_nxt   = 1'b0;
                    consume   = 1'b1;
                    state_nxt = O_OFFER;
                end
            end
            O_OFFER: begin
                if (!rfd) begin
                    dav_nxt   = 1'b1;
                    state_nxt = O_RELEASE;
                end
            end
            O_RELEASE: begin
                if (rfd) begin
                    state_nxt = O_IDLE;
                end
            end
            default: state_nxt = O_IDLE;
        endcase

        if (consume) begin
            pend_v_nxt = 1'b0;
        end

        // A push landing on the same edge that empties pend refills it without loss.
        if (push) begin
            if (!pend_v || consume) begin
                pend_nxt   = data;
                pend_v_nxt = 1'b1;
            end else begin
                lost_nxt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Measures high-pulse widths on `in` and hands each width to a consumer.
// Define PULSE_METER_OVF_EN to add the ovf saturation flag to the result.
//
//   state   | meaning
//   M_WAIT  | input low, waiting for a pulse to start
//   M_CNT   | input high, counting edges (saturating)
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int W = PM_W_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in,
    pulse_meter_if.master bus
);

    localparam logic [W-1:0] CNT_MAX = '1;
`ifdef PULSE_METER_OVF_EN
    localparam int DW = W + 1;
`else
    localparam int DW = W;
`endif

    meas_state_t   state, state_nxt;
    logic [W-1:0]  count, count_nxt;
    logic          push;
    logic [DW-1:0] data;
    logic [DW-1:0] tx_z;
`ifdef PULSE_METER_OVF_EN
    logic          sat, sat_nxt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= M_WAIT;
            count <= '0;
`ifdef PULSE_METER_OVF_EN
            sat   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
`ifdef PULSE_METER_OVF_EN
            sat   <= sat_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        push      = 1'b0;
`ifdef PULSE_METER_OVF_EN
        sat_nxt   = sat;
`endif

        case (state)
            M_WAIT: begin
                if (in) begin
                    count_nxt = W'(1);
                    state_nxt = M_CNT;
`ifdef PULSE_METER_OVF_EN
                    sat_nxt   = 1'b0;
`endif
                end
            end
            M_CNT: begin
                if (in) begin
                    count_nxt = W'(sat_inc(32'(count), 32'(CNT_MAX)));
`ifdef PULSE_METER_OVF_EN
                    // Another high edge while already at max means the true width exceeded it.
                    sat_nxt   = sat | (count == CNT_MAX);
`endif
                end else begin
                    push      = 1'b1;
                    state_nxt = M_WAIT;
                end
            end
            default: state_nxt = M_WAIT;
        endcase
    end

`ifdef PULSE_METER_OVF_EN
    assign data    = {sat, count};
    assign bus.z   = tx_z[W-1:0];
    assign bus.ovf = tx_z[W];
`else
    assign data    = count;
    assign bus.z   = tx_z;
`endif

    pulse_meter_tx #(
        .DW(DW)
    ) u_tx (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .data  (data),
        .rfd   (bus.rfd),
        .dav_  (bus.dav_),
        .z     (tx_z),
        .lost  (bus.lost)
    );

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter: expected widths queued when pulses are driven,
// popped and compared when dav_ falls.
module tb_pulse_meter;

    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pin   = 1'b0;

    pulse_meter_if #(.W(W)) bus ();

    pulse_meter #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .in    (pin),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] z;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    int   checks    = 0;
    int   failures  = 0;
    int   falls     = 0;
    int   low_cnt   = 0;
    int   last_low  = 0;
    int   wait_cnt  = 0;
    int   ack_delay = 0;
    logic hold      = 1'b0;
    logic prev_dav  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Monitor + consumer model, both on the falling edge.
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset) begin
            bus.rfd  = 1'b1;
            wait_cnt = 0;
            low_cnt  = 0;
            prev_dav = 1'b1;
        end else begin
            if (!bus.dav_ && prev_dav) begin
                falls++;
                chk("offer_queued", {31'd0, sb.size() > 0}, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("z", {24'd0, bus.z}, {24'd0, e.z});
`ifdef PULSE_METER_OVF_EN
                    chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
                end
            end
            if (!bus.dav_) begin
                low_cnt++;
            end else if (!prev_dav) begin
                last_low = low_cnt;
                low_cnt  = 0;
            end
            prev_dav = bus.dav_;

            if (!bus.dav_ && !hold) begin
                if (wait_cnt >= ack_delay) bus.rfd = 1'b0;
                else wait_cnt++;
            end else if (bus.dav_) begin
                bus.rfd  = 1'b1;
                wait_cnt = 0;
            end
        end
    end

    task automatic pulse(input int width);
        @(negedge clock);
        pin = 1'b1;
        repeat (width - 1) @(negedge clock);
        @(negedge clock);
        pin = 1'b0;
    endtask

    task automatic send(input int width);
        exp_t e;
        e.z   = (width > MAXV) ? W'(MAXV) : W'(width);
        e.ovf = (width > MAXV);
        sb.push_back(e);
        pulse(width);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.dav_ !== 1'b1) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("drained", {31'd0, (sb.size() == 0) && (bus.dav_ === 1'b1)}, 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int n;

        // Reset state and quiet idle
        reset = 1'b1;
        pin   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_dav", {31'd0, bus.dav_}, 1);
        chk("rst_z", {24'd0, bus.z}, 0);
        chk("rst_lost", {31'd0, bus.lost}, 0);
`ifdef PULSE_METER_OVF_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 0);
`endif
        repeat (20) @(negedge clock);
        chk("idle_falls", falls, 0);

        // Single 20-cycle pulse, consumer acknowledges 3 cycles late
        ack_delay = 3;
        send(20);
        @(posedge clock);
        #1 chk("dav_at_push_edge", {31'd0, bus.dav_}, 1);
        @(posedge clock);
        #1 chk("dav_latency", {31'd0, bus.dav_}, 0);
        chk("z_latency", {24'd0, bus.z}, 20);
        wait_drain(50);
        chk("dav_low_cycles", last_low, 4);
        chk("single_falls", falls, 1);

        // Width boundaries
        ack_delay = 0;
        send(1);
        wait_drain(50);
        chk("fast_ack_low", last_low, 1);
        send(MAXV);
        wait_drain(50);
        send(300);
        wait_drain(50);
        chk("no_loss_yet", {31'd0, bus.lost}, 0);

        // Back-to-back 5,7,9 with consumer stalled: 9 is dropped
        f0   = falls;
        hold = 1'b1;
        send(5);
        send(7);
        pulse(9);
        repeat (40) @(negedge clock);
        chk("lost_set", {31'd0, bus.lost}, 1);
        hold = 1'b0;
        wait_drain(100);
        repeat (10) @(negedge clock);
        chk("lost_sticky", {31'd0, bus.lost}, 1);
        chk("b2b_offers", falls - f0, 2);

        // Reset clears lost; 12 and 15 with a responsive consumer
        do_reset();
        chk("lost_cleared", {31'd0, bus.lost}, 0);
        f0 = falls;
        ack_delay = 0;
        send(12);
        send(15);
        wait_drain(60);
        chk("pair_offers", falls - f0, 2);
        chk("pair_no_loss", {31'd0, bus.lost}, 0);

        // Reset while a result is being offered
        hold = 1'b1;
        send(10);
        n = 0;
        while (bus.dav_ !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("offer_seen", {31'd0, bus.dav_}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 chk("dav_on_reset", {31'd0, bus.dav_}, 1);
        chk("z_on_reset", {24'd0, bus.z}, 0);
        @(negedge clock);
        reset = 1'b0;
        hold  = 1'b0;
        f0    = falls;
        repeat (20) @(negedge clock);
        chk("no_reoffer", falls - f0, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
